serial_tx_uart: RTL and testbench
=================================

// Module: serial_tx_uart
// PURPOSE
//  Consumes the processor's byte-wide serial write port and buffers bytes in a FIFO.
//  Serialises each byte onto an 8N1 UART line: 1 start, 8 data bits LSB first, 1 stop.
//  Sits directly downstream of processor.serial_out / serial_wren_out.
//  Drives processor.serial_ready_in, giving the processor back-pressure.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); legal range >= 2
//  DEPTH         16   FIFO entries; must be a power of two, >= 2
//  ADDR_W        4    log2(DEPTH)
// PORTS
//  clock           in   1         system clock; all logic on posedge
//  reset           in   1         synchronous, active-high
//  serial_in       in   8         byte from processor serial_out
//  serial_wren_in  in   1         active-high write strobe from processor serial_wren_out
//  serial_ready    out  1         high when FIFO not full; feeds processor serial_ready_in
//  tx_out          out  1         UART line, idle high
//  tx_busy         out  1         high while a frame is on the line (START/DATA/STOP)
//  fifo_count      out  ADDR_W+1  bytes currently buffered, 0..DEPTH
//  overflow        out  1         sticky; set when a write arrives while the FIFO is full
// BEHAVIOUR
//  Reset: FIFO pointers and fifo_count = 0; FSM = IDLE; counters = 0.
//   tx_out = 1, tx_busy = 0, overflow = 0, serial_ready = 1.
//   Reset asserted mid-frame aborts the frame; tx_out = 1 on the next edge; buffered bytes are discarded.
//  FIFO:
//   - serial_ready = (fifo_count != DEPTH); combinational from registered state.
//   - Push when serial_wren_in && serial_ready. A write while full is dropped and sets overflow.
//     overflow clears only on reset.
//   - Pop occurs only in IDLE when fifo_count != 0.
//   - Simultaneous push and pop in one cycle leaves fifo_count unchanged; data order is preserved.
//   - Pointers wrap modulo DEPTH.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: tx_out = 1. If fifo_count != 0, pop the head into an 8-bit shift register,
//     clear the bit counter, drive tx_out = 0, and go to START.
//   - START: hold tx_out = 0 for CLKS_PER_BIT cycles. Then drive shreg[0] and go to DATA.
//   - DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right.
//     After bit 7's period, drive tx_out = 1 and go to STOP.
//   - STOP: hold tx_out = 1 for CLKS_PER_BIT cycles, then return to IDLE.
//   - tx_busy = (state != IDLE). tx_out is a registered output.
//  Timing:
//   - A write at edge k into an empty, idle block makes tx_out fall at edge k+1.
//   - Frame length is 10*CLKS_PER_BIT cycles.
//   - Back-to-back buffered bytes have exactly 1 idle-high cycle (the IDLE pop cycle) between the stop bit and the next start bit.
//  Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//   Width is $clog2(CLKS_PER_BIT).
//  Bit counter: 3 bits, counts 0..7 in DATA.
//  serial_in is sampled only on an accepted push; its value at other times is don't-care.
// TESTING (CLKS_PER_BIT=4, DEPTH=4, ADDR_W=2 unless noted)
//  1. Single byte. Reset 10 cycles, then write 0x41 for one cycle.
//     -> tx_out = 0,1,0,0,0,0,0,1,0,1, each held 4 cycles, starting 1 cycle after the write.
//     -> tx_busy high for 40 cycles; fifo_count returns to 0.
//  2. Back-to-back. Write 0x55 then 0xA3 on consecutive cycles.
//     -> both frames decode correctly in order, with exactly 1 high cycle between them.
//  3. Fill and overflow. Hold serial_wren_in high for 6 cycles with bytes 0x01..0x06.
//     -> 0x01 is popped at once and 0x02..0x05 fill the FIFO.
//     -> serial_ready = 0 while fifo_count = 4.
//     -> 0x06 is dropped and overflow = 1.
//     -> the line carries 0x01..0x05 only.
//  4. Simultaneous push and pop. The FIFO holds 2 bytes when a frame ends and IDLE pops
//     while a write arrives. -> fifo_count stays 2; byte order is preserved.
//  5. Reset mid-frame. Assert reset during DATA bit 3 of 0x00.
//     -> the next edge gives tx_out = 1, tx_busy = 0, fifo_count = 0, overflow = 0.
//     -> no residual bits are sent after reset is released.
//  6. Processor integration. Connect to processor with a UART receive model at CLKS_PER_BIT=434.
//     -> the decoded character stream matches the processor's serial writes in order.

Source files
------------

// File: rtl/serial_tx_uart.sv
// Byte-wide write port into a FIFO, drained onto an 8N1 UART line (LSB first).
// Back-pressure is given through serial_ready; overflow is sticky until reset.
module serial_tx_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        serial_in,
    input  logic              serial_wren_in,
    output logic              serial_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;

    logic push;
    logic pop;

    assign serial_ready = (count_q != FULL_CNT);
    assign push         = serial_wren_in && serial_ready;
    assign pop          = (state_q == IDLE) && (count_q != '0);

    assign tx_out     = tx_q;
    assign tx_busy    = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // Storage is not reset: the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= serial_in;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (serial_wren_in && !serial_ready);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shreg_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // tx takes the bit that becomes shreg[0] after this shift.
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_uart.sv
// Directed bench for serial_tx_uart at 4 clocks per bit and a 4-entry FIFO.
// A line decoder pops bytes from exp_q and compares them against each decoded frame.
module tb_serial_tx_uart;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clock;
    logic              reset;
    logic [7:0]        serial_in;
    logic              serial_wren_in;
    logic              serial_ready;
    logic              tx_out;
    logic              tx_busy;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         n_cmp;
    int         n_fail;
    int         cyc;
    logic       mon_abort;

    serial_tx_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_in      (serial_in),
        .serial_wren_in (serial_wren_in),
        .serial_ready   (serial_ready),
        .tx_out         (tx_out),
        .tx_busy        (tx_busy),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write during the next rising edge; call at a falling edge.
    task automatic drive_write(input logic [7:0] b, input logic accept);
        serial_in      = b;
        serial_wren_in = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clock);
        serial_wren_in = 1'b0;
        serial_in      = $urandom_range(0, 255);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 800) begin
            @(negedge clock);
            n++;
        end
        chk("drain_in_time", n < 800, 1);
    endtask

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clock);
            if (reset) mon_abort = 1'b1;
        end
    endtask

    // Line decoder: samples each bit mid-period; a reset abandons the frame.
    initial begin
        logic [7:0] rx;
        int         st;
        mon_abort = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && tx_out === 1'b0) begin
                st        = cyc;
                rx        = '0;
                mon_abort = 1'b0;
                mon_wait(2);
                if (!mon_abort) chk("start_bit", tx_out, 0);
                for (int i = 0; i < 8; i++) begin
                    if (!mon_abort) mon_wait(CPB);
                    if (!mon_abort) rx[i] = tx_out;
                end
                if (!mon_abort) mon_wait(CPB);
                if (!mon_abort) begin
                    chk("stop_bit", tx_out, 1);
                    start_q.push_back(st);
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("rx_byte", rx, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [9:0]  fr;
        logic [7:0]  b4;
        logic [2:0]  exp_cnt [6];
        n_cmp          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        serial_wren_in = 1'b0;
        serial_in      = 8'h00;

        // Reset state
        repeat (10) @(negedge clock);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", serial_ready, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1. Single byte, cycle-exact line pattern
        drive_write(8'h41, 1'b1);
        chk("t1_tx_before", tx_out, 1);
        chk("t1_count_after_push", fifo_count, 1);
        fr = {1'b1, 8'h41, 1'b0};
        for (int j = 0; j < 10 * CPB; j++) begin
            @(negedge clock);
            chk("t1_tx", tx_out, fr[j / CPB]);
            chk("t1_busy", tx_busy, 1);
        end
        @(negedge clock);
        chk("t1_tx_end", tx_out, 1);
        chk("t1_busy_end", tx_busy, 0);
        chk("t1_count_end", fifo_count, 0);
        wait_drain();

        // 2. Back-to-back writes
        start_q.delete();
        drive_write(8'h55, 1'b1);
        drive_write(8'hA3, 1'b1);
        wait_drain();
        chk("t2_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("t2_gap", start_q[1] - start_q[0], 10 * CPB + 1);

        // 3. Fill and overflow
        start_q.delete();
        exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 6; i++) begin
            chk("t3_count", fifo_count, exp_cnt[i]);
            chk("t3_ready", serial_ready, (i < 5));
            drive_write(8'(i + 1), i < 5);
        end
        chk("t3_ovf", overflow, 1);
        chk("t3_count_full", fifo_count, 4);
        chk("t3_ready_full", serial_ready, 0);
        wait_drain();
        chk("t3_frames", start_q.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (start_q.size() == 5) chk("t3_gap", start_q[i] - start_q[i-1], 10 * CPB + 1);
        end
        chk("t3_ovf_sticky", overflow, 1);

        // 4. Push coincident with IDLE pop, FIFO holding 2
        start_q.delete();
        drive_write(8'hC1, 1'b1);
        drive_write(8'h3C, 1'b1);
        drive_write(8'h96, 1'b1);
        repeat (10 * CPB - 1) @(negedge clock);
        chk("t4_count_pre", fifo_count, 2);
        chk("t4_busy_pre", tx_busy, 0);
        b4 = 8'($urandom_range(0, 255));
        drive_write(b4, 1'b1);
        chk("t4_count_same", fifo_count, 2);
        chk("t4_busy_post", tx_busy, 1);
        @(negedge clock);
        chk("t4_count_hold", fifo_count, 2);
        wait_drain();
        chk("t4_frames", start_q.size(), 4);

        // 5. Reset during data bit 3 of 0x00
        drive_write(8'h00, 1'b1);
        repeat (18) @(negedge clock);
        chk("t5_busy_mid", tx_busy, 1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk("t5_tx", tx_out, 1);
        chk("t5_busy", tx_busy, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_ready", serial_ready, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start_q.delete();
        for (int j = 0; j < 12 * CPB; j++) begin
            @(negedge clock);
            chk("t5_idle_tx", tx_out, 1);
        end
        chk("t5_no_frames", start_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
